flght_seq: RTL and testbench
============================

// Module: flght_seq
// PURPOSE
//  Flight sequencer in front of flght_cntrl. Runs power-up inertial calibration
//  by driving flght_cntrl.inertial_cal, arms the craft and slew-limits commanded
//  thrust into flght_cntrl.thrst. Runs a controlled auto-land when inertial data
//  stops arriving or landing is commanded. Sits between the command interface
//  and flght_cntrl; mtrs_off gates the ESC outputs downstream of flght_cntrl.
// PARAMETERS
//  CAL_TMO    1000000  cycles allowed in CAL before giving up (cal_err)
//  VLD_TMO    65536    cycles without vld in ARMED before forced LAND
//  LAND_DIV   4096     cycles between thrust decrements in LAND
//  RAMP_STEP  8        max thrust change per step (9-bit units)
// PORTS
//  clk           in   1  system clock
//  rst_n         in   1  asynchronous active-low reset
//  strt_cal      in   1  one-cycle pulse: start calibration (honoured in IDLE only)
//  cal_done      in   1  inertial integrator reports calibration complete
//  vld           in   1  new inertial sample valid (same strobe as flght_cntrl.vld)
//  cmd_thrst     in   9  commanded thrust, unsigned
//  land_cmd      in   1  pulse: request auto-land
//  emer_stop     in   1  level: kill motors immediately
//  inertial_cal  out  1  to flght_cntrl.inertial_cal
//  thrst         out  9  to flght_cntrl.thrst, slew-limited
//  mtrs_off      out  1  1 = force all motor speeds to zero
//  armed         out  1  1 while in ARMED
//  cal_err       out  1  sticky: calibration timed out; cleared by next accepted strt_cal
//  state         out  2  IDLE=0 CAL=1 ARMED=2 LAND=3
// BEHAVIOUR
//  - All outputs registered; each output changes 1 cycle after its causing event.
//  - Reset: state=IDLE, inertial_cal=0, thrst=0, mtrs_off=1, armed=0, cal_err=0,
//    all counters 0.
//  - IDLE: mtrs_off=1, thrst=0. strt_cal -> CAL, clear cal_err, clear cal counter.
//  - CAL: inertial_cal=1, mtrs_off=0, thrst=0, cal counter increments every cycle.
//    cal_done -> ARMED. Counter reaches CAL_TMO-1 with no cal_done -> IDLE and
//    cal_err=1. When cal_done and timeout occur in the same cycle, cal_done wins.
//  - ARMED: inertial_cal=0, mtrs_off=0, armed=1. On each vld, thrst steps toward
//    cmd_thrst: if |cmd_thrst-thrst|<=RAMP_STEP then thrst=cmd_thrst, else
//    thrst +/- RAMP_STEP. Compute in 10 bits and never wrap (thrst stays 0..511).
//    Watchdog counter clears on vld and increments otherwise; at VLD_TMO-1 -> LAND.
//    land_cmd -> LAND. When land_cmd and vld coincide, enter LAND with no thrust
//    step applied. strt_cal is ignored in ARMED.
//  - LAND: armed=0, cmd_thrst ignored, vld ignored. Every LAND_DIV cycles (free-
//    running divider, cleared on LAND entry), thrst -= RAMP_STEP, saturating at 0.
//    The first divider terminal count with thrst==0 -> IDLE (mtrs_off=1).
//    strt_cal and land_cmd are ignored.
//  - emer_stop (highest priority, any state): next cycle state=IDLE, thrst=0,
//    mtrs_off=1, inertial_cal=0, armed=0. cal_err is held. A strt_cal that
//    coincides with emer_stop is dropped.
//  - Asynchronous reset mid-operation drops to the reset values immediately.
// CONFIGURATION
//  THRST_SLEW_EN defined: ARMED slew-limits as above.
//  THRST_SLEW_EN undefined: in ARMED, thrst<=cmd_thrst on each vld (no limit).
//  LAND ramp-down, watchdog and all other behaviour are identical in both builds.
// TESTING  (bench params: CAL_TMO=100 VLD_TMO=50 LAND_DIV=4 RAMP_STEP=8)
//  1. Reset, strt_cal, cal_done 20 cycles later -> inertial_cal=1 for 20 cycles,
//     then state=2, armed=1, mtrs_off=0, thrst=0.
//  2. strt_cal, no cal_done -> IDLE after 100 cycles with cal_err=1, mtrs_off=1;
//     a second strt_cal clears cal_err.
//  3. ARMED, cmd_thrst=100, vld every 10 cycles -> thrst 8,16,...,96,100 on
//     successive vld, then held at 100; cmd_thrst=0 -> thrst steps down by 8.
//     Without THRST_SLEW_EN -> thrst=100 after the first vld.
//  4. ARMED with thrst=20, vld stops -> LAND after 50 cycles; thrst 12,4,0 at 4-cycle
//     intervals, then IDLE with mtrs_off=1.
//  5. ARMED with thrst=100, emer_stop pulse -> next cycle thrst=0, state=0,
//     mtrs_off=1; land_cmd+vld in the same cycle -> LAND, thrst unchanged.
//  6. Assert rst_n=0 mid-CAL -> all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/flght_seq.sv
// Flight sequencer: power-up calibration, arming, thrust slewing and auto-land in front of flght_cntrl.
// Optional feature macro THRST_SLEW_EN: when defined, ARMED thrust is slew-limited by RAMP_STEP per vld.
module flght_seq #(
    parameter int unsigned CAL_TMO   = 1000000,
    parameter int unsigned VLD_TMO   = 65536,
    parameter int unsigned LAND_DIV  = 4096,
    parameter int unsigned RAMP_STEP = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       strt_cal,
    input  logic       cal_done,
    input  logic       vld,
    input  logic [8:0] cmd_thrst,
    input  logic       land_cmd,
    input  logic       emer_stop,
    output logic       inertial_cal,
    output logic [8:0] thrst,
    output logic       mtrs_off,
    output logic       armed,
    output logic       cal_err,
    output logic [1:0] state
);

    localparam int unsigned CAL_CW = (CAL_TMO  > 1) ? $clog2(CAL_TMO)  : 1;
    localparam int unsigned WD_CW  = (VLD_TMO  > 1) ? $clog2(VLD_TMO)  : 1;
    localparam int unsigned DIV_CW = (LAND_DIV > 1) ? $clog2(LAND_DIV) : 1;

    localparam logic [CAL_CW-1:0] CAL_LAST = CAL_CW'(CAL_TMO - 1);
    localparam logic [WD_CW-1:0]  WD_LAST  = WD_CW'(VLD_TMO - 1);
    localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(LAND_DIV - 1);
    localparam logic [9:0]        STEP10   = 10'(RAMP_STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CAL   = 2'd1,
        S_ARMED = 2'd2,
        S_LAND  = 2'd3
    } state_e;

    state_e              r_state;
    logic [8:0]          r_thrst;
    logic                r_mtrs_off;
    logic                r_armed;
    logic                r_inertial_cal;
    logic                r_cal_err;
    logic [CAL_CW-1:0]   r_cal_cnt;
    logic [WD_CW-1:0]    r_wd_cnt;
    logic [DIV_CW-1:0]   r_div_cnt;

    state_e              w_state_nx;
    logic [8:0]          w_thrst_nx;
    logic                w_cal_err_nx;
    logic [CAL_CW-1:0]   w_cal_cnt_nx;
    logic [WD_CW-1:0]    w_wd_cnt_nx;
    logic [DIV_CW-1:0]   w_div_cnt_nx;
    logic [9:0]          w_thrst10;
    logic [9:0]          w_land_thrst;

`ifdef THRST_SLEW_EN
    logic [9:0]          w_cmd10;
    logic [9:0]          w_slew_thrst;

    // Difference is taken in 10 bits in the direction of travel so it never underflows.
    always_comb begin
        w_cmd10 = {1'b0, cmd_thrst};
        if (w_cmd10 >= w_thrst10) begin
            if ((w_cmd10 - w_thrst10) <= STEP10) w_slew_thrst = w_cmd10;
            else                                 w_slew_thrst = w_thrst10 + STEP10;
        end else begin
            if ((w_thrst10 - w_cmd10) <= STEP10) w_slew_thrst = w_cmd10;
            else                                 w_slew_thrst = w_thrst10 - STEP10;
        end
    end
`endif

    assign w_thrst10    = {1'b0, r_thrst};
    assign w_land_thrst = (w_thrst10 <= STEP10) ? '0 : (w_thrst10 - STEP10);

    always_comb begin
        w_state_nx   = r_state;
        w_thrst_nx   = r_thrst;
        w_cal_err_nx = r_cal_err;
        w_cal_cnt_nx = r_cal_cnt;
        w_wd_cnt_nx  = r_wd_cnt;
        w_div_cnt_nx = r_div_cnt;

        if (emer_stop) begin
            w_state_nx   = S_IDLE;
            w_thrst_nx   = '0;
            w_cal_cnt_nx = '0;
            w_wd_cnt_nx  = '0;
            w_div_cnt_nx = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_thrst_nx = '0;
                    if (strt_cal) begin
                        w_state_nx   = S_CAL;
                        w_cal_err_nx = 1'b0;
                        w_cal_cnt_nx = '0;
                    end
                end
                S_CAL: begin
                    w_thrst_nx   = '0;
                    w_cal_cnt_nx = r_cal_cnt + 1'b1;
                    if (cal_done) begin
                        w_state_nx   = S_ARMED;
                        w_wd_cnt_nx  = '0;
                        w_cal_cnt_nx = '0;
                    end else if (r_cal_cnt == CAL_LAST) begin
                        w_state_nx   = S_IDLE;
                        w_cal_err_nx = 1'b1;
                        w_cal_cnt_nx = '0;
                    end
                end
                S_ARMED: begin
                    if (land_cmd) begin
                        w_state_nx   = S_LAND;
                        w_div_cnt_nx = '0;
                    end else if (vld) begin
                        w_wd_cnt_nx = '0;
`ifdef THRST_SLEW_EN
                        w_thrst_nx  = w_slew_thrst[8:0];
`else
                        w_thrst_nx  = cmd_thrst;
`endif
                    end else if (r_wd_cnt == WD_LAST) begin
                        w_state_nx   = S_LAND;
                        w_wd_cnt_nx  = '0;
                        w_div_cnt_nx = '0;
                    end else begin
                        w_wd_cnt_nx = r_wd_cnt + 1'b1;
                    end
                end
                S_LAND: begin
                    if (r_div_cnt == DIV_LAST) begin
                        w_div_cnt_nx = '0;
                        if (r_thrst == '0) w_state_nx = S_IDLE;
                        else               w_thrst_nx = w_land_thrst[8:0];
                    end else begin
                        w_div_cnt_nx = r_div_cnt + 1'b1;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_thrst        <= '0;
            r_mtrs_off     <= 1'b1;
            r_armed        <= 1'b0;
            r_inertial_cal <= 1'b0;
            r_cal_err      <= 1'b0;
            r_cal_cnt      <= '0;
            r_wd_cnt       <= '0;
            r_div_cnt      <= '0;
        end else begin
            r_state        <= w_state_nx;
            r_thrst        <= w_thrst_nx;
            r_mtrs_off     <= (w_state_nx == S_IDLE);
            r_armed        <= (w_state_nx == S_ARMED);
            r_inertial_cal <= (w_state_nx == S_CAL);
            r_cal_err      <= w_cal_err_nx;
            r_cal_cnt      <= w_cal_cnt_nx;
            r_wd_cnt       <= w_wd_cnt_nx;
            r_div_cnt      <= w_div_cnt_nx;
        end
    end

    assign inertial_cal = r_inertial_cal;
    assign thrst        = r_thrst;
    assign mtrs_off     = r_mtrs_off;
    assign armed        = r_armed;
    assign cal_err      = r_cal_err;
    assign state        = r_state;

endmodule

// File: tb/tb_flght_seq.sv
// Directed bench for flght_seq: stimulus queues expected outputs per cycle, a negedge monitor checks them.
module tb_flght_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       strt_cal, cal_done, vld, land_cmd, emer_stop;
    logic [8:0] cmd_thrst;
    logic       inertial_cal, mtrs_off, armed, cal_err;
    logic [8:0] thrst;
    logic [1:0] state;

    flght_seq #(
        .CAL_TMO  (100),
        .VLD_TMO  (50),
        .LAND_DIV (4),
        .RAMP_STEP(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .strt_cal    (strt_cal),
        .cal_done    (cal_done),
        .vld         (vld),
        .cmd_thrst   (cmd_thrst),
        .land_cmd    (land_cmd),
        .emer_stop   (emer_stop),
        .inertial_cal(inertial_cal),
        .thrst       (thrst),
        .mtrs_off    (mtrs_off),
        .armed       (armed),
        .cal_err     (cal_err),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic [14:0] val;   // {state, thrst, mtrs_off, armed, inertial_cal, cal_err}
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [14:0] act;
        exp_t        e;
        act = {state, thrst, mtrs_off, armed, inertial_cal, cal_err};
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_chk++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: checked late at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
            end else if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: actual st=%0d th=%0d mo=%b ar=%b ic=%b ce=%b, required st=%0d th=%0d mo=%b ar=%b ic=%b ce=%b",
                         e.name, act[14:13], act[12:4], act[3], act[2], act[1], act[0],
                         e.val[14:13], e.val[12:4], e.val[3], e.val[2], e.val[1], e.val[0]);
            end
        end
    end

    task automatic push(input string nm, input logic [1:0] st, input logic [8:0] th,
                        input logic mo, input logic ar, input logic ic, input logic ce);
        exp_t e;
        e.cyc  = cyc;
        e.name = nm;
        e.val  = {st, th, mo, ar, ic, ce};
        q.push_back(e);
    endtask

    task automatic exp_idle(input string nm, input logic ce);
        push(nm, 2'd0, 9'd0, 1'b1, 1'b0, 1'b0, ce);
    endtask
    task automatic exp_cal(input string nm);
        push(nm, 2'd1, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask
    task automatic exp_armed(input string nm, input logic [8:0] th);
        push(nm, 2'd2, th, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic exp_land(input string nm, input logic [8:0] th);
        push(nm, 2'd3, th, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

`ifdef THRST_SLEW_EN
    int up[14]   = '{8, 16, 24, 32, 40, 48, 56, 64, 72, 80, 88, 96, 100, 100};
    int dn[3]    = '{92, 84, 76};
    int to20[7]  = '{68, 60, 52, 44, 36, 28, 20};
    int n_up     = 13;
`else
    int up[14]   = '{100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100};
    int dn[3]    = '{0, 0, 0};
    int to20[7]  = '{20, 20, 20, 20, 20, 20, 20};
    int n_up     = 1;
`endif

    initial begin
        rst_n = 1'b0; strt_cal = 1'b0; cal_done = 1'b0; vld = 1'b0;
        land_cmd = 1'b0; emer_stop = 1'b0; cmd_thrst = '0;
        step(2);
        exp_idle("reset", 1'b0);
        rst_n = 1'b1;
        step(2);

        // Calibration completing after 20 cycles
        strt_cal = 1'b1; step(1); strt_cal = 1'b0;
        exp_cal("cal_enter");
        for (int i = 1; i < 20; i++) begin
            step(1);
            exp_cal($sformatf("cal_hold%0d", i));
        end
        cal_done = 1'b1; step(1); cal_done = 1'b0;
        exp_armed("armed_enter", 9'd0);

        // Ramp up, down, then settle at 20
        cmd_thrst = 9'd100;
        for (int k = 0; k < 14; k++) begin
            step(9); vld = 1'b1; step(1); vld = 1'b0;
            exp_armed($sformatf("ramp_up%0d", k), 9'(up[k]));
        end
        cmd_thrst = 9'd0;
        for (int k = 0; k < 3; k++) begin
            step(9); vld = 1'b1; step(1); vld = 1'b0;
            exp_armed($sformatf("ramp_dn%0d", k), 9'(dn[k]));
        end
        cmd_thrst = 9'd20;
        for (int k = 0; k < 7; k++) begin
            step(9); vld = 1'b1; step(1); vld = 1'b0;
            exp_armed($sformatf("ramp_20_%0d", k), 9'(to20[k]));
        end

        // Watchdog expiry and auto-land ramp
        step(48); exp_armed("wd_48", 9'd20);
        step(1);  exp_armed("wd_49", 9'd20);
        step(1);  exp_land("wd_land", 9'd20);
        step(3);  exp_land("land_div3", 9'd20);
        step(1);  exp_land("land_12", 9'd12);
        step(4);  exp_land("land_4", 9'd4);
        step(4);  exp_land("land_0", 9'd0);
        step(3);  exp_land("land_0_hold", 9'd0);
        step(1);  exp_idle("land_idle", 1'b0);

        // Calibration timeout, sticky error, clear on restart
        step(2);
        strt_cal = 1'b1; step(1); strt_cal = 1'b0;
        exp_cal("tmo_enter");
        step(99); exp_cal("tmo_last");
        step(1);  exp_idle("tmo_idle", 1'b1);
        step(3);  exp_idle("tmo_sticky", 1'b1);
        emer_stop = 1'b1; step(1); emer_stop = 1'b0;
        exp_idle("emer_holds_err", 1'b1);
        strt_cal = 1'b1; step(1); strt_cal = 1'b0;
        exp_cal("err_cleared");
        step(99);
        cal_done = 1'b1; step(1); cal_done = 1'b0;
        exp_armed("cal_done_wins", 9'd0);

        // Emergency stop from ARMED at thrust 100
        cmd_thrst = 9'd100; vld = 1'b1;
        for (int k = 0; k < n_up; k++) begin
            step(1);
            exp_armed($sformatf("ramp2_%0d", k), 9'(up[k]));
        end
        vld = 1'b0;
        strt_cal = 1'b1; step(1); strt_cal = 1'b0;
        exp_armed("strt_ignored", 9'd100);
        emer_stop = 1'b1; strt_cal = 1'b1; step(1); emer_stop = 1'b0; strt_cal = 1'b0;
        exp_idle("emer_stop", 1'b0);
        step(1); exp_idle("strt_dropped", 1'b0);

        // land_cmd coinciding with vld
        strt_cal = 1'b1; step(1); strt_cal = 1'b0;
        cal_done = 1'b1; step(1); cal_done = 1'b0;
        exp_armed("rearm", 9'd0);
        vld = 1'b1;
        for (int k = 0; k < n_up; k++) step(1);
        exp_armed("rearm_100", 9'd100);
        cmd_thrst = 9'd0; land_cmd = 1'b1;
        step(1); vld = 1'b0; land_cmd = 1'b0;
        exp_land("land_vld", 9'd100);
        vld = 1'b1; step(1); vld = 1'b0;
        exp_land("land_vld_ign", 9'd100);

        // Asynchronous reset mid-CAL
        emer_stop = 1'b1; step(1); emer_stop = 1'b0;
        exp_idle("emer_land", 1'b0);
        strt_cal = 1'b1; step(1); strt_cal = 1'b0;
        exp_cal("cal_pre_rst");
        step(5);
        #1 rst_n = 1'b0;
        exp_idle("async_rst", 1'b0);
        step(2);
        rst_n = 1'b1;
        step(2); exp_idle("post_rst", 1'b0);
        step(3);

        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
